// File: rtl/stopwatch_counter.sv
// Minutes:seconds BCD stopwatch (00:00..MAX_MIN:MAX_SEC) driven by tick clock enables.
// Optional digit-blink mask for the adjust field is enabled with `define STOPWATCH_BLINK_EN.
module stopwatch_counter #(
   parameter int MAX_MIN = 99,
   parameter int MAX_SEC = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       pause_pulse,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
`ifdef STOPWATCH_BLINK_EN
   output logic [3:0] blank,
`endif
   output logic       rollover
);

   typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_ADJUST} state_t;

   localparam logic [3:0] MIN_T = 4'(MAX_MIN / 10);
   localparam logic [3:0] MIN_O = 4'(MAX_MIN % 10);
   localparam logic [3:0] SEC_T = 4'(MAX_SEC / 10);
   localparam logic [3:0] SEC_O = 4'(MAX_SEC % 10);

   state_t state;

   // Returns {wrapped, tens, ones}; a wrap clears both digits.
   function automatic logic [8:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                          input logic [3:0] mt, input logic [3:0] mo);
      logic [8:0] r;
      if (t == mt && o == mo) r = {1'b1, 4'd0, 4'd0};
      else if (o == 4'd9)     r = {1'b0, t + 4'd1, 4'd0};
      else                    r = {1'b0, t, o + 4'd1};
      return r;
   endfunction

   logic [8:0] sec_nx, min_nx;
   assign sec_nx = bcd_inc(sec_tens, sec_ones, SEC_T, SEC_O);
   assign min_nx = bcd_inc(min_tens, min_ones, MIN_T, MIN_O);

   assign running = (state == ST_RUN);

`ifdef STOPWATCH_BLINK_EN
   logic       blink;
   logic       blink_nx;
   logic [3:0] sel_mask;
   assign blink_nx = tick_2hz ? ~blink : blink;
   assign sel_mask = sel ? 4'b0011 : 4'b1100;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_PAUSED;
         min_tens <= '0;
         min_ones <= '0;
         sec_tens <= '0;
         sec_ones <= '0;
         rollover <= 1'b0;
`ifdef STOPWATCH_BLINK_EN
         blink    <= 1'b0;
         blank    <= '0;
`endif
      end else begin
         rollover <= 1'b0;
`ifdef STOPWATCH_BLINK_EN
         blank    <= '0;
`endif
         if (adj) begin
            // The entry cycle only switches state; field edits start once in ADJUST.
            if (state != ST_ADJUST) begin
               state <= ST_ADJUST;
`ifdef STOPWATCH_BLINK_EN
               blink <= 1'b0;
`endif
            end else begin
               if (tick_2hz) begin
                  if (sel) {sec_tens, sec_ones} <= sec_nx[7:0];
                  else     {min_tens, min_ones} <= min_nx[7:0];
               end
`ifdef STOPWATCH_BLINK_EN
               blink <= blink_nx;
               blank <= blink_nx ? sel_mask : 4'b0000;
`endif
            end
         end else if (state == ST_ADJUST) begin
            state <= ST_PAUSED;
`ifdef STOPWATCH_BLINK_EN
            blink <= 1'b0;
`endif
         end else if (state == ST_RUN) begin
            if (tick_1hz) begin
               {sec_tens, sec_ones} <= sec_nx[7:0];
               if (sec_nx[8]) begin
                  {min_tens, min_ones} <= min_nx[7:0];
                  rollover             <= min_nx[8];
               end
            end
            if (pause_pulse) state <= ST_PAUSED;
         end else if (pause_pulse) begin
            state <= ST_RUN;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed plan steps followed by random stimulus,
// every cycle compared against an integer minutes/seconds reference model.
module tb_stopwatch_counter;
   localparam int MAX_MIN = 99;
   localparam int MAX_SEC = 59;

   logic       clk = 1'b0;
   logic       rst, tick_1hz, tick_2hz, pause_pulse, adj, sel;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, rollover;
`ifdef STOPWATCH_BLINK_EN
   logic [3:0] blank;
`endif

   stopwatch_counter #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running),
`ifdef STOPWATCH_BLINK_EN
      .blank(blank),
`endif
      .rollover(rollover)
   );

   always #5 clk = ~clk;

   int n_asrt = 0;
   int n_fail = 0;

   // Reference model: plain integer time and a mode number (0 paused, 1 run, 2 adjust).
   int m_min = 0, m_sec = 0, m_mode = 0, m_roll = 0, m_blink = 0, m_blank = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit t1, input bit t2, input bit pp,
                             input bit a, input bit sl);
      if (r) begin
         m_min = 0; m_sec = 0; m_mode = 0; m_roll = 0; m_blink = 0; m_blank = 0;
         return;
      end
      m_roll = 0;
      m_blank = 0;
      if (a) begin
         if (m_mode != 2) begin
            m_mode = 2; m_blink = 0;
         end else begin
            if (t2) begin
               m_blink ^= 1;
               if (sl) m_sec = (m_sec + 1) % (MAX_SEC + 1);
               else    m_min = (m_min + 1) % (MAX_MIN + 1);
            end
            if (m_blink != 0) m_blank = sl ? 3 : 12;
         end
      end else if (m_mode == 2) begin
         m_mode = 0;
      end else if (m_mode == 1) begin
         if (t1) begin
            int total;
            total = m_min * (MAX_SEC + 1) + m_sec + 1;
            if (total == (MAX_MIN + 1) * (MAX_SEC + 1)) begin
               total = 0; m_roll = 1;
            end
            m_min = total / (MAX_SEC + 1);
            m_sec = total % (MAX_SEC + 1);
         end
         if (pp) m_mode = 0;
      end else if (pp) begin
         m_mode = 1;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".min_tens"}, 32'(min_tens), 32'(m_min / 10));
      chk({tag, ".min_ones"}, 32'(min_ones), 32'(m_min % 10));
      chk({tag, ".sec_tens"}, 32'(sec_tens), 32'(m_sec / 10));
      chk({tag, ".sec_ones"}, 32'(sec_ones), 32'(m_sec % 10));
      chk({tag, ".running"},  32'(running),  32'(m_mode == 1));
      chk({tag, ".rollover"}, 32'(rollover), 32'(m_roll));
`ifdef STOPWATCH_BLINK_EN
      chk({tag, ".blank"},    32'(blank),    32'(m_blank));
`endif
   endtask

   task automatic cyc(input string tag, input bit r, input bit t1, input bit t2,
                      input bit pp, input bit a, input bit sl);
      rst = r; tick_1hz = t1; tick_2hz = t2; pause_pulse = pp; adj = a; sel = sl;
      @(posedge clk);
      model_step(r, t1, t2, pp, a, sl);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         cyc(tag, 0, 1, 0, 0, 0, 0);
         cyc(tag, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic adj_ticks(input string tag, input bit sl, input int n);
      for (int i = 0; i < n; i++) begin
         cyc(tag, 0, 0, 1, 0, 1, sl);
         cyc(tag, 0, 0, 0, 0, 1, sl);
      end
   endtask

   initial begin
      rst = 1; tick_1hz = 0; tick_2hz = 0; pause_pulse = 0; adj = 0; sel = 0;
      cyc("reset", 1, 0, 0, 0, 0, 0);
      chk("reset.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0000);
      chk("reset.running", 32'(running), 0);

      // Ticks while paused are ignored.
      run_ticks("paused_ticks", 3);
      chk("paused.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0000);

      cyc("start", 0, 0, 0, 1, 0, 0);
      run_ticks("run61", 61);
      chk("run61.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0101);
      chk("run61.running", 32'(running), 1);
      cyc("pause", 0, 0, 0, 1, 0, 0);
      run_ticks("held", 5);
      chk("held.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0101);

      // Preload 99:59: from 01:01 advance minutes by 98 and seconds by 58.
      cyc("adj_enter", 0, 0, 0, 0, 1, 0);
      adj_ticks("adj_min", 0, 98);
      adj_ticks("adj_sec", 1, 58);
      chk("preload.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h9959);
      cyc("adj_exit", 0, 0, 0, 0, 0, 0);
      cyc("resume", 0, 0, 0, 1, 0, 0);
      cyc("wrap", 0, 1, 0, 0, 0, 0);
      chk("wrap.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0000);
      chk("wrap.rollover", 32'(rollover), 1);
      cyc("wrap_after", 0, 0, 0, 0, 0, 0);
      chk("wrap_after.rollover", 32'(rollover), 0);

      // Seconds wrap in ADJUST without carrying; tick_1hz ignored there.
      cyc("pause2", 0, 0, 0, 1, 0, 0);
      cyc("adj2_enter", 0, 0, 0, 0, 1, 1);
      adj_ticks("adj_to58", 1, 58);
      for (int i = 0; i < 60; i++) begin
         cyc("adj_sweep", 0, 0, 1, 0, 1, 1);
         cyc("adj_t1", 0, 1, 0, 1, 1, 1);
      end
      chk("sweep.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0058);

      // Coincident pause and tick in RUN at 00:09, then reset.
      cyc("adj3_exit", 0, 0, 0, 0, 0, 0);
      cyc("adj4_enter", 0, 0, 0, 0, 1, 1);
      adj_ticks("adj_to09", 1, 11);
      cyc("adj4_exit", 0, 0, 0, 0, 0, 0);
      cyc("run9", 0, 0, 0, 1, 0, 0);
      cyc("coinc", 0, 1, 0, 1, 0, 0);
      chk("coinc.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0010);
      chk("coinc.running", 32'(running), 0);
      cyc("coinc_p", 0, 1, 0, 1, 0, 0);
      cyc("rst2", 1, 1, 1, 1, 0, 0);
      chk("rst2.digits", {min_tens, min_ones, sec_tens, sec_ones}, 32'h0000);
      chk("rst2.running", 32'(running), 0);

`ifdef STOPWATCH_BLINK_EN
      cyc("blink_enter", 0, 0, 0, 0, 1, 0);
      chk("blink.b0", 32'(blank), 32'b0000);
      cyc("blink_t1", 0, 0, 1, 0, 1, 0);
      chk("blink.b1", 32'(blank), 32'b1100);
      cyc("blink_t2", 0, 0, 1, 0, 1, 0);
      chk("blink.b2", 32'(blank), 32'b0000);
      cyc("blink_exit", 0, 0, 0, 0, 0, 0);
      chk("blink.b3", 32'(blank), 32'b0000);
`endif

      // Random phase: adj and reset held rarely, ticks and presses frequent.
      begin
         bit a = 0;
         bit sl = 0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) a = ~a;
            if ($urandom_range(0, 15) == 0) sl = ~sl;
            cyc("rand", $urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, a, sl);
         end
      end

      idle("tail", 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
